bin_to_bcd_seq: RTL and testbench

Sequential double-dabble converter that turns an unsigned binary word into packed BCD digits, one shift per clock. It sits directly upstream of the per-digit 7-segment decoders in the DDS display path. It takes the binary frequency/step value from the DDS control logic and drives each decoder's 4-bit `dec` input from one nibble of `bcd`. A start/busy/done handshake lets the controller launch a conversion whenever the displayed value changes.

---
 rtl/dds_disp_pkg.sv | 19 +
 rtl/bin_to_bcd_seq_if.sv | 28 ++
 rtl/bcd_digit_adj.sv | 18 +
 rtl/bin_to_bcd_seq.sv | 113 +++++++++++
 tb/tb_bin_to_bcd_seq.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/dds_disp_pkg.sv
// dds_disp_pkg: shared types and constants for the DDS display path.
//   state_e        - bin_to_bcd_seq converter states (IDLE, SHIFT, DONE)
//   BCD_DIGIT_W    - bits per packed BCD digit
//   BCD_ADJ_THRESH - double-dabble adjust threshold (digit >= 5)
//   BCD_ADJ_ADD    - double-dabble adjust addend (+3)
package dds_disp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_e;

  localparam int unsigned BCD_DIGIT_W = 4;

  localparam logic [BCD_DIGIT_W-1:0] BCD_ADJ_THRESH = 4'd5;
  localparam logic [BCD_DIGIT_W-1:0] BCD_ADJ_ADD    = 4'd3;

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// bin_to_bcd_seq_if: start/busy/done handshake and data bus of the
// binary-to-BCD converter.
//   start, bin               - request and operand (controller -> converter)
//   busy, done, bcd, overflow - status and packed BCD result (converter -> controller)
// Modports: master (controller side), slave (converter side).
interface bin_to_bcd_seq_if #(
  parameter int unsigned BIN_W  = 14,
  parameter int unsigned DIGITS = 4
);

  logic                  start;
  logic [BIN_W-1:0]      bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic                  overflow;

  modport master (
    output start, bin,
    input  busy, done, bcd, overflow
  );

  modport slave (
    input  start, bin,
    output busy, done, bcd, overflow
  );

endinterface

// File: rtl/bcd_digit_adj.sv
// bcd_digit_adj: combinational double-dabble digit correction.
//   digit_i - current scratch BCD digit
//   digit_o - digit_i + 3 when digit_i >= 5, else digit_i
module bcd_digit_adj
  import dds_disp_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit_i,
  output logic [BCD_DIGIT_W-1:0] digit_o
);

  always_comb begin
    digit_o = digit_i;
    if (digit_i >= BCD_ADJ_THRESH) begin
      digit_o = digit_i + BCD_ADJ_ADD;
    end
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential double-dabble binary-to-packed-BCD converter,
// one shift per clock, period BIN_W+2 cycles.
//   clk - rising-edge clock
//   rst - synchronous active-high reset
//   bus - bin_to_bcd_seq_if.slave: start/bin in; busy/done/bcd/overflow out
// Build option: define BIN_TO_BCD_SAT_EN to saturate bcd to all nines on
// overflow; otherwise bcd holds bin mod 10^DIGITS. overflow is set either way.
module bin_to_bcd_seq
  import dds_disp_pkg::*;
#(
  parameter int unsigned BIN_W  = 14,
  parameter int unsigned DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  bin_to_bcd_seq_if.slave     bus
);

  localparam int unsigned BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);

  state_e             state_q, state_d;
  logic [BIN_W-1:0]   sr_q, sr_d;
  logic [BCD_W-1:0]   scr_q, scr_d, scr_adj;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sticky_q, sticky_d;
  logic               ovf_q, ovf_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_i (scr_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .digit_o (scr_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    scr_d    = scr_q;
    bcd_d    = bcd_q;
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    ovf_d    = ovf_q;
    // Status flags are a one-cycle-delayed decode of the current state.
    busy_d   = (state_q != ST_IDLE);
    done_d   = (state_q == ST_DONE);

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          sr_d     = bus.bin;
          scr_d    = '0;
          sticky_d = 1'b0;
          cnt_d    = CNT_W'(BIN_W);
          state_d  = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // Adjusted scratch and operand shift as one register; the top
        // scratch bit falls off into the sticky overflow flag.
        {scr_d, sr_d} = {scr_adj[BCD_W-2:0], sr_q, 1'b0};
        sticky_d      = sticky_q | scr_adj[BCD_W-1];
        cnt_d         = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
`ifdef BIN_TO_BCD_SAT_EN
        bcd_d = sticky_q ? {DIGITS{4'd9}} : scr_q;
`else
        bcd_d = scr_q;
`endif
        ovf_d   = sticky_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      sr_q     <= '0;
      scr_q    <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      scr_q    <= scr_d;
      bcd_q    <= bcd_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.bcd      = bcd_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq: directed self-checking bench for bin_to_bcd_seq
// (defaults BIN_W=14, DIGITS=4). Honours BIN_TO_BCD_SAT_EN for the
// overflow expectation.
module tb_bin_to_bcd_seq;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  bin_to_bcd_seq_if #(.BIN_W(14), .DIGITS(4)) bus ();

  bin_to_bcd_seq #(.BIN_W(14), .DIGITS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference: decimal digits by division, packed as BCD.
  function automatic logic [15:0] ref_bcd(input int unsigned v);
    logic [15:0] r;
    r = '0;
    for (int unsigned d = 0; d < 4; d++) begin
      r[d*4 +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // Launch one conversion from IDLE; returns edges from accept to done and
  // the number of those cycles with busy high. Ends #1 after the done edge.
  task automatic run_conv(input logic [13:0] v, output int lat, output int busy_cnt);
    @(negedge clk);
    bus.start = 1'b1;
    bus.bin   = v;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.bin   = 14'($urandom);
    lat = 0;
    busy_cnt = 0;
    while (bus.done !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.busy === 1'b1) busy_cnt++;
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, bcnt, ndone, k;
    logic [15:0] exp_sat;

    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.bin   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_bcd",  32'(bus.bcd), 0);
    check("rst_ovf",  32'(bus.overflow), 0);
    @(negedge clk);
    rst = 1'b0;

    // Zero: latency and busy width.
    run_conv(14'd0, lat, bcnt);
    check("zero_lat",  32'(lat), 15);
    check("zero_busy", 32'(bcnt), 15);
    check("zero_bcd",  32'(bus.bcd), 32'h0000);
    check("zero_ovf",  32'(bus.overflow), 0);
    @(posedge clk); #1;
    check("zero_busy_drop", 32'(bus.busy), 0);
    check("zero_done_pulse", 32'(bus.done), 0);

    run_conv(14'd1234, lat, bcnt);
    check("v1234_lat", 32'(lat), 15);
    check("v1234_bcd", 32'(bus.bcd), 32'h1234);
    repeat (10) @(posedge clk);
    #1;
    check("hold_bcd",  32'(bus.bcd), 32'h1234);
    check("hold_done", 32'(bus.done), 0);

    run_conv(14'd9999, lat, bcnt);
    check("v9999_bcd", 32'(bus.bcd), 32'h9999);
    check("v9999_ovf", 32'(bus.overflow), 0);

`ifdef BIN_TO_BCD_SAT_EN
    exp_sat = 16'h9999;
`else
    exp_sat = 16'h2345;
`endif
    run_conv(14'd12345, lat, bcnt);
    check("v12345_bcd", 32'(bus.bcd), 32'(exp_sat));
    check("v12345_ovf", 32'(bus.overflow), 1);
    repeat (5) @(posedge clk);
    #1;
    check("ovf_hold", 32'(bus.overflow), 1);

`ifdef BIN_TO_BCD_SAT_EN
    exp_sat = 16'h9999;
`else
    exp_sat = 16'h6383;
`endif
    run_conv(14'd16383, lat, bcnt);
    check("v16383_bcd", 32'(bus.bcd), 32'(exp_sat));
    check("v16383_ovf", 32'(bus.overflow), 1);

    run_conv(14'd10, lat, bcnt);
    check("v10_bcd", 32'(bus.bcd), 32'h0010);
    check("v10_ovf_clr", 32'(bus.overflow), 0);

    // start held high with bin changing every cycle: accepts at k=0,16,32.
    ndone = 0;
    for (int i = 0; i < 48; i++) begin
      @(negedge clk);
      bus.start = 1'b1;
      bus.bin   = 14'(100 + i);
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) begin
        ndone++;
        check($sformatf("held_done%0d_cycle", ndone), 32'(i), 32'(16 * ndone - 1));
        check($sformatf("held_done%0d_bcd", ndone), 32'(bus.bcd),
              32'(ref_bcd(100 + 16 * (ndone - 1))));
      end
    end
    @(negedge clk);
    bus.start = 1'b0;
    check("held_ndone", 32'(ndone), 3);
    repeat (3) @(posedge clk);

    // start pulses while busy are ignored.
    @(negedge clk);
    bus.start = 1'b1;
    bus.bin   = 14'd2468;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) ndone++;
      bus.start = (i == 3 || i == 8 || i == 14) ? 1'b1 : 1'b0;
      bus.bin   = 14'd5555;
      if (i == 20) begin
        bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
    check("busy_start_ndone", 32'(ndone), 1);
    check("busy_start_bcd", 32'(bus.bcd), 32'h2468);

    // Reset 5 cycles into a conversion, with start asserted alongside rst.
    @(negedge clk);
    bus.start = 1'b1;
    bus.bin   = 14'd4321;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.start = 1'b0;
    check("abort_busy", 32'(bus.busy), 0);
    check("abort_bcd",  32'(bus.bcd), 0);
    check("abort_ovf",  32'(bus.overflow), 0);
    ndone = 0;
    k = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) ndone++;
      if (bus.busy === 1'b1) k++;
    end
    check("abort_no_done", 32'(ndone), 0);
    check("abort_no_busy", 32'(k), 0);
    run_conv(14'd4321, lat, bcnt);
    check("after_abort_bcd", 32'(bus.bcd), 32'h4321);
    check("after_abort_lat", 32'(lat), 15);

    // Strided sweep of the in-range values against the division model.
    for (int unsigned v = 0; v <= 9999; v += 13) begin
      run_conv(14'(v), lat, bcnt);
      check($sformatf("sweep_%0d", v), {15'(lat), bus.overflow, bus.bcd},
            {15'd15, 1'b0, ref_bcd(v)});
    end
    for (int unsigned v = 9990; v <= 9999; v++) begin
      run_conv(14'(v), lat, bcnt);
      check($sformatf("edge_%0d", v), {15'(lat), bus.overflow, bus.bcd},
            {15'd15, 1'b0, ref_bcd(v)});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
